check_position_router: RTL and testbench

- Parametrised successor to the fixed 4-bit position checker used in the NoC node.
- Takes a destination address (X,Y) per packet header and compares it with the node's own position.
- Emits two decisions per packet:
  - core_contr: eject to the local core, or forward.
  - router_contr: output direction.
- Adds a decision FIFO, XY/YX routing mode, independent (forked) consumption of the two outputs, and saturating traffic counters.
- Sits between the header-extract stage and the router crossbar/core interface, clocked on the synchronous NoC wrapper domain.

---
 rtl/check_position_pkg.sv | 22 ++
 rtl/check_position_fifo.sv | 60 ++++++
 rtl/check_position_router.sv | 133 +++++++++++++
 tb/tb_check_position_router.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/check_position_pkg.sv
// Shared types for the position-check router: output directions,
// routing-order selectors and the decision record held in the FIFO.
package check_position_pkg;

    typedef enum logic [1:0] {
        DIR_E = 2'b00,
        DIR_W = 2'b01,
        DIR_N = 2'b10,
        DIR_S = 2'b11
    } dir_t;

    localparam int ROUTE_XY = 0;
    localparam int ROUTE_YX = 1;

    typedef struct packed {
        logic core;
        dir_t dir;
    } decision_t;

    localparam int DEC_W = $bits(decision_t);

endpackage

// File: rtl/check_position_fifo.sv
// Generic synchronous FIFO with async active-low reset. Pushes when full
// and pops when empty are ignored, so callers may drive raw requests.
module check_position_fifo #(
    parameter  int DEPTH = 4,
    parameter  int DW    = 3,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage array; cleared on reset so the head is never undefined.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; count tracks fill.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/check_position_router.sv
// NoC node position checker: compares a header's destination with this
// node's coordinates, queues the eject/forward + direction decision, and
// presents it on two independently handshaked (forked) output channels.
module check_position_router
    import check_position_pkg::*;
#(
    parameter  int XW         = 2,
    parameter  int YW         = 2,
    parameter  int MY_X       = 0,
    parameter  int MY_Y       = 0,
    parameter  int DEPTH      = 4,
    parameter  int ROUTE_MODE = 0,
    parameter  int CNT_W      = 8,
    localparam int OCC_W      = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             _RESET,
    input  logic [XW+YW-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             core_contr,
    output logic             core_valid,
    input  logic             core_ready,
    output logic [1:0]       router_contr,
    output logic             router_valid,
    input  logic             router_ready,
    output logic [CNT_W-1:0] local_cnt,
    output logic [CNT_W-1:0] fwd_cnt,
    output logic [OCC_W-1:0] occupancy
);

    localparam logic [XW-1:0] LP_MY_X = XW'(MY_X);
    localparam logic [YW-1:0] LP_MY_Y = YW'(MY_Y);

    logic [XW-1:0]    w_dst_x;
    logic [YW-1:0]    w_dst_y;
    decision_t        w_dec;
    decision_t        w_head;
    logic [DEC_W-1:0] w_fifo_rd;
    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_core_hs;
    logic             w_router_hs;
    logic             w_core_done;
    logic             w_router_done;
    logic             w_pop;
    logic             r_core_sent;
    logic             r_router_sent;
    logic [CNT_W-1:0] r_local_cnt;
    logic [CNT_W-1:0] r_fwd_cnt;

    assign w_dst_x  = in_data[XW-1:0];
    assign w_dst_y  = in_data[XW+YW-1:XW];
    // Reset is folded in so the producer sees backpressure while held in reset.
    assign in_ready = !w_full && _RESET;
    assign w_accept = in_valid && in_ready;

    // Route decision: eject on exact match, otherwise dimension-order toward dest.
    always_comb begin
        w_dec.core = 1'b0;
        w_dec.dir  = DIR_E;
        if (w_dst_x == LP_MY_X && w_dst_y == LP_MY_Y) begin
            w_dec.core = 1'b1;
        end else if (ROUTE_MODE == ROUTE_YX) begin
            if (w_dst_y != LP_MY_Y) w_dec.dir = (w_dst_y > LP_MY_Y) ? DIR_N : DIR_S;
            else                    w_dec.dir = (w_dst_x > LP_MY_X) ? DIR_E : DIR_W;
        end else begin
            if (w_dst_x != LP_MY_X) w_dec.dir = (w_dst_x > LP_MY_X) ? DIR_E : DIR_W;
            else                    w_dec.dir = (w_dst_y > LP_MY_Y) ? DIR_N : DIR_S;
        end
    end

    check_position_fifo #(
        .DEPTH (DEPTH),
        .DW    (DEC_W)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (_RESET),
        .i_push  (w_accept),
        .i_data  (w_dec),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rd),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (occupancy)
    );

    assign w_head = decision_t'(w_fifo_rd);

    // Fork: each channel is offered the head once; it pops when both are done.
    assign core_valid    = !w_empty && !r_core_sent;
    assign router_valid  = !w_empty && !r_router_sent;
    assign core_contr    = !w_empty && w_head.core;
    assign router_contr  = w_empty ? 2'b00 : w_head.dir;
    assign w_core_hs     = core_valid && core_ready;
    assign w_router_hs   = router_valid && router_ready;
    assign w_core_done   = r_core_sent || w_core_hs;
    assign w_router_done = r_router_sent || w_router_hs;
    assign w_pop         = !w_empty && w_core_done && w_router_done;

    // Sent-flags remember a finished channel until its partner catches up.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            r_core_sent   <= 1'b0;
            r_router_sent <= 1'b0;
        end else if (w_pop) begin
            r_core_sent   <= 1'b0;
            r_router_sent <= 1'b0;
        end else begin
            if (w_core_hs)   r_core_sent   <= 1'b1;
            if (w_router_hs) r_router_sent <= 1'b1;
        end
    end

    // Saturating traffic counters, split by the decision made at accept.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            r_local_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else if (w_accept) begin
            if (w_dec.core) begin
                if (r_local_cnt != '1) r_local_cnt <= r_local_cnt + CNT_W'(1);
            end else begin
                if (r_fwd_cnt != '1)   r_fwd_cnt   <= r_fwd_cnt + CNT_W'(1);
            end
        end
    end

    assign local_cnt = r_local_cnt;
    assign fwd_cnt   = r_fwd_cnt;

endmodule

// File: tb/tb_check_position_router.sv
// Directed bench: three routers (XY/8-bit, YX/8-bit, XY/2-bit counters)
// at node (1,2) share one stimulus stream; each output is checked against
// hand-derived values.
module tb_check_position_router;

    logic       CLK = 1'b0;
    logic       _RESET;
    logic [3:0] in_data;
    logic       in_valid;
    logic       core_ready;
    logic       router_ready;

    logic       rdy_a, cc_a, cv_a, rv_a;
    logic [1:0] rc_a;
    logic [7:0] lc_a, fc_a;
    logic [2:0] occ_a;
    logic       rdy_b, cc_b, cv_b, rv_b;
    logic [1:0] rc_b;
    logic [7:0] lc_b, fc_b;
    logic [2:0] occ_b;
    logic       rdy_c, cc_c, cv_c, rv_c;
    logic [1:0] rc_c;
    logic [1:0] lc_c, fc_c;
    logic [2:0] occ_c;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    check_position_router #(.XW(2), .YW(2), .MY_X(1), .MY_Y(2), .DEPTH(4),
                            .ROUTE_MODE(0), .CNT_W(8)) dut_a (
        .CLK(CLK), ._RESET(_RESET), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_a), .core_contr(cc_a), .core_valid(cv_a), .core_ready(core_ready),
        .router_contr(rc_a), .router_valid(rv_a), .router_ready(router_ready),
        .local_cnt(lc_a), .fwd_cnt(fc_a), .occupancy(occ_a));

    check_position_router #(.XW(2), .YW(2), .MY_X(1), .MY_Y(2), .DEPTH(4),
                            .ROUTE_MODE(1), .CNT_W(8)) dut_b (
        .CLK(CLK), ._RESET(_RESET), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_b), .core_contr(cc_b), .core_valid(cv_b), .core_ready(core_ready),
        .router_contr(rc_b), .router_valid(rv_b), .router_ready(router_ready),
        .local_cnt(lc_b), .fwd_cnt(fc_b), .occupancy(occ_b));

    check_position_router #(.XW(2), .YW(2), .MY_X(1), .MY_Y(2), .DEPTH(4),
                            .ROUTE_MODE(0), .CNT_W(2)) dut_c (
        .CLK(CLK), ._RESET(_RESET), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_c), .core_contr(cc_c), .core_valid(cv_c), .core_ready(core_ready),
        .router_contr(rc_c), .router_valid(rv_c), .router_ready(router_ready),
        .local_cnt(lc_c), .fwd_cnt(fc_c), .occupancy(occ_c));

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Header encoding: {Y[1:0], X[1:0]}
    initial begin
        _RESET       = 1'b0;
        in_data      = 4'h0;
        in_valid     = 1'b0;
        core_ready   = 1'b1;
        router_ready = 1'b1;
        #12;
        chk("rst_in_ready", rdy_a, 0);
        chk("rst_occ",      occ_a, 0);
        chk("rst_core_v",   cv_a,  0);
        chk("rst_rtr_v",    rv_a,  0);
        chk("rst_lcnt",     lc_a,  0);
        #5 _RESET = 1'b1;
        #1;
        chk("rel_in_ready", rdy_a, 1);
        tick();

        // Local destination (1,2)
        in_data = 4'b1001; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk("loc_core_v",  cv_a, 1);
        chk("loc_rtr_v",   rv_a, 1);
        chk("loc_core",    cc_a, 1);
        chk("loc_dir",     rc_a, 2'b00);
        chk("loc_lcnt",    lc_a, 1);
        chk("loc_occ",     occ_a, 1);
        tick();
        chk("loc_gone_v",  cv_a, 0);
        chk("loc_gone_occ", occ_a, 0);

        // (3,0): XY east, YX south
        in_data = 4'b0011; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk("e_core",   cc_a, 0);
        chk("e_dir_xy", rc_a, 2'b00);
        chk("e_dir_yx", rc_b, 2'b11);
        chk("e_fcnt_xy", fc_a, 1);
        chk("e_fcnt_yx", fc_b, 1);
        tick();

        // (0,3): XY west, YX north
        in_data = 4'b1100; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk("w_dir_xy", rc_a, 2'b01);
        chk("w_dir_yx", rc_b, 2'b10);
        tick();

        // (1,3): north in both modes
        in_data = 4'b1101; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk("n_dir_xy", rc_a, 2'b10);
        chk("n_dir_yx", rc_b, 2'b10);
        tick();

        // Fill with consumers stalled: 5 offered, 4 fit
        core_ready = 1'b0; router_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 4'b1001; tick();
        in_data = 4'b0011; tick();
        in_data = 4'b1100; tick();
        in_data = 4'b1101; tick();
        chk("full_occ",   occ_a, 4);
        chk("full_ready", rdy_a, 0);
        in_data = 4'b0001; tick();
        chk("full_occ2",  occ_a, 4);
        in_valid = 1'b0;
        core_ready = 1'b1; router_ready = 1'b1;
        #1;
        chk("nowt_ready", rdy_a, 0);
        chk("drain0_core", cc_a, 1);
        chk("drain0_dir",  rc_a, 2'b00);
        tick();
        chk("drain1_core", cc_a, 0);
        chk("drain1_dir",  rc_a, 2'b00);
        chk("drain1_occ",  occ_a, 3);
        tick();
        chk("drain2_dir",  rc_a, 2'b01);
        tick();
        chk("drain3_dir",  rc_a, 2'b10);
        chk("drain3_v",    cv_a, 1);
        tick();
        chk("drain_occ",   occ_a, 0);
        chk("drain_ready", rdy_a, 1);
        chk("drain_lcnt",  lc_a, 2);
        chk("drain_fcnt",  fc_a, 6);
        chk("sat_fcnt",    fc_c, 3);

        // Three more local packets back to back: 2-bit counter saturates
        in_data = 4'b1001; in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        chk("bb_occ",    occ_a, 1);
        tick();
        chk("sat_lcnt_a", lc_a, 5);
        chk("sat_lcnt_c", lc_c, 3);

        // Fork skew: core consumes, router stalls
        router_ready = 1'b0;
        in_data = 4'b0011; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk("skew_cv0", cv_a, 1);
        tick();
        chk("skew_cv1", cv_a, 0);
        chk("skew_rv1", rv_a, 1);
        chk("skew_occ1", occ_a, 1);
        tick();
        chk("skew_cv2", cv_a, 0);
        chk("skew_occ2", occ_a, 1);
        chk("skew_dir", rc_b, 2'b11);
        router_ready = 1'b1;
        tick();
        chk("skew_occ3", occ_a, 0);
        chk("skew_rv3",  rv_a, 0);

        // Async reset mid-drain
        core_ready = 1'b0; router_ready = 1'b0;
        in_data = 4'b1001; in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        chk("pre_rst_occ", occ_a, 3);
        #2 _RESET = 1'b0;
        #1;
        chk("arst_occ",   occ_a, 0);
        chk("arst_cv",    cv_a, 0);
        chk("arst_rv",    rv_a, 0);
        chk("arst_cc",    cc_a, 0);
        chk("arst_lcnt",  lc_a, 0);
        chk("arst_fcnt",  fc_a, 0);
        chk("arst_ready", rdy_a, 0);
        #4 _RESET = 1'b1;
        core_ready = 1'b1; router_ready = 1'b1;
        tick();
        chk("post_cv",  cv_a, 0);
        chk("post_rv",  rv_a, 0);
        chk("post_occ", occ_a, 0);
        chk("post_rdy", rdy_a, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
